p_mul_seq: RTL and testbench

//  Issue sequencer directly upstream of the packed multiplier p_mul.
//  - Accepts one packed mul/clmul request at a time from the core with a valid/ready handshake.
//  - Latches the operands and holds them stable at the multiplier until it reports ready.
//  - Captures the multiplier result into a response register and presents it to the core with a

---
 rtl/p_mul_seq_pkg.sv | 33 +++
 rtl/p_mul_seq_chk.sv | 30 +++
 rtl/p_mul_seq.sv | 191 +++++++++++++++++++
 tb/tb_p_mul_seq.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_mul_seq_pkg.sv
// ----------------------------------------------------------------------------
// p_mul_seq_pkg
// Shared definitions for the p_mul issue sequencer:
//   - one-hot pack-width encodings (PW_32 .. PW_2)
//   - sequencer state encoding (S_IDLE / S_RUN / S_RESP)
//   - result struct of the request legality / zero checker
//   - one-hot test helper
// ----------------------------------------------------------------------------
package p_mul_seq_pkg;

    localparam logic [4:0] PW_32 = 5'b00001;
    localparam logic [4:0] PW_16 = 5'b00010;
    localparam logic [4:0] PW_8  = 5'b00100;
    localparam logic [4:0] PW_4  = 5'b01000;
    localparam logic [4:0] PW_2  = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic illegal;
        logic zero_op;
    } chk_t;

    // True when exactly one bit of the pack-width field is set.
    function automatic logic is_onehot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/p_mul_seq_chk.sv
// ----------------------------------------------------------------------------
// p_mul_seq_chk
// Combinational request screening for the p_mul issue sequencer.
//   i_mul_l, i_mul_h  requested product half (exactly one must be set)
//   i_pw              one-hot pack width
//   i_rs1, i_rs2      operands
//   o_chk             {illegal, zero_op}
//     illegal : pw not one-hot, or mul_l == mul_h
//     zero_op : either operand is zero (product is trivially 0)
// ----------------------------------------------------------------------------
module p_mul_seq_chk
    import p_mul_seq_pkg::*;
(
    input  logic        i_mul_l,
    input  logic        i_mul_h,
    input  logic [4:0]  i_pw,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output chk_t        o_chk
);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        o_chk         = '0;
        o_chk.illegal = !is_onehot5(i_pw) || (i_mul_l == i_mul_h);
        o_chk.zero_op = (i_rs1 == 32'd0) || (i_rs2 == 32'd0);
    end

endmodule

// File: rtl/p_mul_seq.sv
// ----------------------------------------------------------------------------
// p_mul_seq
// Issue sequencer in front of the packed multiplier p_mul. Accepts one
// mul/clmul request, holds latched operands at p_mul until it reports ready,
// and returns the captured result through a response handshake. Illegal
// encodings and zero operands are answered directly without starting p_mul.
//
// Ports
//   clock, resetn               clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake
//   req_mul_l/_h, req_clmul     operation select
//   req_pw[4:0]                 one-hot pack width (32/16/8/4/2)
//   req_rs1, req_rs2            operands
//   rsp_valid / rsp_ready       response handshake
//   rsp_result, rsp_err         result (0 when rsp_err)
//   mul_valid / mul_ready       p_mul handshake
//   mul_mul_l/_h, mul_clmul,
//   mul_pw, mul_crs1, mul_crs2  latched operation to p_mul
//   mul_result                  p_mul result, valid with mul_ready
//   perf_ops, perf_busy         performance counters (P_MUL_SEQ_PERF_EN only)
//
// Configuration: define P_MUL_SEQ_PERF_EN to add the perf_ops / perf_busy
// counters (CNT_W bits, wrapping).
// ----------------------------------------------------------------------------
module p_mul_seq
    import p_mul_seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mul_l,
    input  logic              req_mul_h,
    input  logic              req_clmul,
    input  logic [4:0]        req_pw,
    input  logic [31:0]       req_rs1,
    input  logic [31:0]       req_rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_result,
    output logic              rsp_err,
    output logic              mul_valid,
    input  logic              mul_ready,
    output logic              mul_mul_l,
    output logic              mul_mul_h,
    output logic              mul_clmul,
    output logic [4:0]        mul_pw,
    output logic [31:0]       mul_crs1,
    output logic [31:0]       mul_crs2,
    input  logic [31:0]       mul_result
`ifdef P_MUL_SEQ_PERF_EN
   ,output logic [CNT_W-1:0]  perf_ops,
    output logic [CNT_W-1:0]  perf_busy
`endif
);

    state_t      r_state;
    logic        r_req_ready;
    logic        r_mul_valid;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_result;
    logic        r_mul_l;
    logic        r_mul_h;
    logic        r_clmul;
    logic [4:0]  r_pw;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    chk_t        w_chk;

    // Screening looks at the live request; its verdict is only used in the
    // accepting cycle, after which everything runs from the latched copy.
    p_mul_seq_chk u_chk (
        .i_mul_l (req_mul_l),
        .i_mul_h (req_mul_h),
        .i_pw    (req_pw),
        .i_rs1   (req_rs1),
        .i_rs2   (req_rs2),
        .o_chk   (w_chk)
    );

    // req_ready is registered so it stays low while resetn is low and only
    // rises on the first clock after release.
    // NOTE: state registers use non-blocking assignments so every register
    // in this block samples pre-edge values, independent of statement order.
    // NOTE: the operand registers are few and drive outputs, so they are
    // reset along with the control state rather than left uninitialised.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_mul_valid  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_result <= 32'd0;
            r_mul_l      <= 1'b0;
            r_mul_h      <= 1'b0;
            r_clmul      <= 1'b0;
            r_pw         <= 5'd0;
            r_rs1        <= 32'd0;
            r_rs2        <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_mul_l     <= req_mul_l;
                        r_mul_h     <= req_mul_h;
                        r_clmul     <= req_clmul;
                        r_pw        <= req_pw;
                        r_rs1       <= req_rs1;
                        r_rs2       <= req_rs2;
                        if (w_chk.illegal || w_chk.zero_op) begin
                            // Answered locally; p_mul is never started.
                            r_rsp_result <= 32'd0;
                            r_rsp_err    <= w_chk.illegal;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_mul_valid <= 1'b1;
                            r_state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (mul_ready) begin
                        // Dropping mul_valid here keeps p_mul from re-arming.
                        r_mul_valid  <= 1'b0;
                        r_rsp_result <= mul_result;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_mul_valid <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign mul_valid  = r_mul_valid;
    assign mul_mul_l  = r_mul_l;
    assign mul_mul_h  = r_mul_h;
    assign mul_clmul  = r_clmul;
    assign mul_pw     = r_pw;
    assign mul_crs1   = r_rs1;
    assign mul_crs2   = r_rs2;

`ifdef P_MUL_SEQ_PERF_EN
    logic [CNT_W-1:0] r_perf_ops;
    logic [CNT_W-1:0] r_perf_busy;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_perf_ops  <= '0;
            r_perf_busy <= '0;
        end else begin
            if (r_rsp_valid && rsp_ready)
                r_perf_ops <= r_perf_ops + 1'b1;
            if (r_state == S_RUN)
                r_perf_busy <= r_perf_busy + 1'b1;
        end
    end

    assign perf_ops  = r_perf_ops;
    assign perf_busy = r_perf_busy;
`else
    // CNT_W only sizes the perf counters, which are absent in this build.
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_p_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_p_mul_seq
// Bench for p_mul_seq with a behavioural p_mul model (ready after W+1 cycles
// of mul_valid) and a scoreboard queue of expected responses.
// ----------------------------------------------------------------------------
module tb_p_mul_seq;

    logic        clock;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_mul_l;
    logic        req_mul_h;
    logic        req_clmul;
    logic [4:0]  req_pw;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        mul_valid;
    logic        mul_ready;
    logic        mul_mul_l;
    logic        mul_mul_h;
    logic        mul_clmul;
    logic [4:0]  mul_pw;
    logic [31:0] mul_crs1;
    logic [31:0] mul_crs2;
    logic [31:0] mul_result;
`ifdef P_MUL_SEQ_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_busy;
`endif

    p_mul_seq #(.CNT_W(32)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mul_l  (req_mul_l),
        .req_mul_h  (req_mul_h),
        .req_clmul  (req_clmul),
        .req_pw     (req_pw),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .mul_valid  (mul_valid),
        .mul_ready  (mul_ready),
        .mul_mul_l  (mul_mul_l),
        .mul_mul_h  (mul_mul_h),
        .mul_clmul  (mul_clmul),
        .mul_pw     (mul_pw),
        .mul_crs1   (mul_crs1),
        .mul_crs2   (mul_crs2),
        .mul_result (mul_result)
`ifdef P_MUL_SEQ_PERF_EN
       ,.perf_ops   (perf_ops),
        .perf_busy  (perf_busy)
`endif
    );

    // ---------------- golden packed multiply ----------------
    function automatic int pw_w(input logic [4:0] pw);
        case (pw)
            5'b00001: return 32;
            5'b00010: return 16;
            5'b00100: return 8;
            5'b01000: return 4;
            5'b10000: return 2;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [31:0] gold(input logic mh, input logic cl,
                                         input logic [4:0] pw,
                                         input logic [31:0] a, input logic [31:0] b);
        int w;
        logic [63:0] m, x, y, p;
        logic [31:0] r;
        w = pw_w(pw);
        r = 32'd0;
        if (w == 0) return r;
        m = (64'd1 << w) - 64'd1;
        for (int l = 0; l < 32 / w; l++) begin
            x = ({32'd0, a} >> (l * w)) & m;
            y = ({32'd0, b} >> (l * w)) & m;
            p = 64'd0;
            if (cl) begin
                for (int i = 0; i < w; i++)
                    if (y[i]) p = p ^ (x << i);
            end else begin
                p = x * y;
            end
            p = mh ? ((p >> w) & m) : (p & m);
            r = r | (p[31:0] << (l * w));
        end
        return r;
    endfunction

    // ---------------- behavioural p_mul ----------------
    int   pm_cnt;
    logic pm_rdy;
    logic spur;        // forces a stray mul_ready pulse

    always @(posedge clock or negedge resetn) begin
        if (!resetn)                  pm_cnt <= 0;
        else if (mul_valid && !pm_rdy) pm_cnt <= pm_cnt + 1;
        else                          pm_cnt <= 0;
    end
    assign pm_rdy     = mul_valid && (pm_cnt == pw_w(mul_pw));
    assign mul_ready  = pm_rdy | spur;
    assign mul_result = spur ? 32'hDEAD_BEEF :
                        (pm_rdy ? gold(mul_mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2)
                                : 32'hBAD0_BAD0);

    // ---------------- clock, cycle count ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- response-ready control ----------------
    int mode;   // 0: always ready, 1: held low, 2: random
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            rsp_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
        int          mv;
        int          t;
    } exp_t;
    exp_t sb[$];

    int   mv_cnt;
    logic prev_rv;
    int   exp_ops;
    int   exp_busy;

    // Monitor: latency on rsp_valid rise, data on handshake.
    always @(negedge clock) begin
        exp_t e;
        if (!resetn) begin
            mv_cnt   = 0;
            prev_rv  = 1'b0;
            exp_ops  = 0;
            exp_busy = 0;
        end else begin
            if (mul_valid) mv_cnt++;
            if (rsp_valid && !prev_rv && sb.size() > 0)
                check("rsp_latency", 64'(cyc - sb[0].t), 64'(sb[0].lat));
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rsp_result", 64'(rsp_result), 64'(e.res));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    check("mul_valid_cycles", 64'(mv_cnt), 64'(e.mv));
                    exp_ops++;
                    exp_busy += e.mv;
                end
                mv_cnt = 0;
            end
            prev_rv = rsp_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic ml, input logic mh, input logic cl,
                         input logic [4:0] pw, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee, input int lat, input int mv,
                         input bit push, output int t);
        exp_t e;
        @(negedge clock);
        req_mul_l = ml;
        req_mul_h = mh;
        req_clmul = cl;
        req_pw    = pw;
        req_rs1   = a;
        req_rs2   = b;
        req_valid = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if (req_ready) break;
            @(negedge clock);
        end
        check("req_accepted", 64'(req_ready), 64'd1);
        t = cyc;
        if (push) begin
            e.res = er; e.err = ee; e.lat = lat; e.mv = mv; e.t = t;
            sb.push_back(e);
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (sb.size() == 0 && !rsp_valid) break;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int w;
        logic [4:0]  pw;
        logic [31:0] a, b, er;
        logic ml, cl, zero;

        mode      = 0;
        spur      = 1'b0;
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_mul_l = 1'b0;
        req_mul_h = 1'b0;
        req_clmul = 1'b0;
        req_pw    = 5'd0;
        req_rs1   = 32'd0;
        req_rs2   = 32'd0;

        // Reset state
        @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mul_valid", 64'(mul_valid), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_mul_ops", 64'({mul_mul_l, mul_mul_h, mul_clmul, mul_pw}), 64'd0);
        check("rst_mul_crs", 64'({mul_crs1, mul_crs2}), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("idle_req_ready", 64'(req_ready), 64'd1);

        // 1. basic 32-bit multiply
        issue(1, 0, 0, 5'b00001, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 0, 34, 33, 1, t);
        drain();
        // 2. 32-bit high half
        issue(0, 1, 0, 5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 34, 33, 1, t);
        drain();
        // Other widths / clmul
        issue(1, 0, 0, 5'b00010, 32'h0003_0002, 32'h0004_0005, 32'h000C_000A, 0, 18, 17, 1, t);
        issue(1, 0, 1, 5'b00100, 32'h0303_0303, 32'h0303_0303, 32'h0505_0505, 0, 10, 9, 1, t);
        issue(1, 0, 0, 5'b01000, 32'h1111_1111, 32'h7777_7777, 32'h7777_7777, 0, 6, 5, 1, t);
        issue(0, 1, 0, 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 0, 4, 3, 1, t);
        // 3. zero and error paths
        issue(1, 0, 0, 5'b00001, 32'h0000_1234, 32'h0000_0000, 32'h0, 0, 1, 0, 1, t);
        issue(1, 0, 0, 5'b00100, 32'h0000_0000, 32'h0000_0007, 32'h0, 0, 1, 0, 1, t);
        issue(1, 0, 0, 5'b00011, 32'h0000_0003, 32'h0000_0005, 32'h0, 1, 1, 0, 1, t);
        issue(1, 1, 0, 5'b00001, 32'h0000_0003, 32'h0000_0005, 32'h0, 1, 1, 0, 1, t);
        issue(0, 0, 0, 5'b00001, 32'h0000_0003, 32'h0000_0005, 32'h0, 1, 1, 0, 1, t);
        issue(1, 0, 0, 5'b00000, 32'h0000_0003, 32'h0000_0005, 32'h0, 1, 1, 0, 1, t);
        drain();

        // Stray mul_ready while idle
        @(negedge clock);
        spur = 1'b1;
        @(negedge clock);
        spur = 1'b0;
        @(negedge clock);
        check("idle_spur_rsp_valid", 64'(rsp_valid), 64'd0);
        check("idle_spur_req_ready", 64'(req_ready), 64'd1);

        // 4. backpressure
        mode = 1;
        issue(1, 0, 0, 5'b00100, 32'h0202_0202, 32'h0303_0303, 32'h0606_0606, 0, 10, 9, 1, t);
        for (int k = 0; k < 100; k++) begin
            if (rsp_valid) break;
            @(negedge clock);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_result", 64'(rsp_result), 64'h0606_0606);
            check("bp_rsp_err", 64'(rsp_err), 64'd0);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            spur = (i == 1);
            if (i == 2) begin
                // request while busy must be ignored
                req_pw    = 5'b00000;
                req_valid = 1'b1;
            end
            if (i == 4) req_valid = 1'b0;
        end
        mode = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (rsp_valid && rsp_ready) break;
        end
        @(negedge clock);
        check("bp_post_req_ready", 64'(req_ready), 64'd1);
        check("bp_post_rsp_valid", 64'(rsp_valid), 64'd0);
        drain();

        // 5. reset mid-operation (discarded, nothing pushed)
        issue(1, 0, 0, 5'b00001, 32'h1234_5678, 32'h0000_0009, 32'h0, 0, 0, 0, 0, t);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (cyc == t + 10) break;
        end
        check("pre_reset_mul_valid", 64'(mul_valid), 64'd1);
        resetn = 1'b0;
        #1;
        check("reset_mul_valid", 64'(mul_valid), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
        end
        issue(1, 0, 0, 5'b00010, 32'h0005_0007, 32'h0006_0003, 32'h001E_0015, 0, 18, 17, 1, t);
        drain();

        // 6. random sweep with random rsp_ready
        mode = 2;
        for (int n = 0; n < 40; n++) begin
            w    = 32 >> $urandom_range(0, 4);
            pw   = 5'(pw_w(5'b00001) / w);     // 32/w is a power of two: one-hot position
            pw   = (w == 32) ? 5'b00001 : (w == 16) ? 5'b00010 : (w == 8) ? 5'b00100 :
                   (w == 4) ? 5'b01000 : 5'b10000;
            ml   = 1'($urandom_range(0, 1));
            cl   = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            zero = ($urandom_range(0, 7) == 0);
            if (zero) b = 32'd0;
            er   = zero ? 32'd0 : gold(!ml, cl, pw, a, b);
            issue(ml, !ml, cl, pw, a, b, er, 0, zero ? 1 : 2 + w, zero ? 0 : w + 1, 1, t);
        end
        mode = 0;
        drain();

`ifdef P_MUL_SEQ_PERF_EN
        @(posedge clock);
        #1;
        check("perf_ops", 64'(perf_ops), 64'(exp_ops));
        check("perf_busy", 64'(perf_busy), 64'(exp_busy));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
